// File: rtl/exe_stage_mc.sv
// rtl/exe_stage_mc.sv - multi-cycle execute stage with EXE/MEM register
// Optional iterative multiplier (cmd 1010) is enabled by defining EXE_MUL_EN.
module exe_stage_mc #(
    parameter int DATA_W   = 32,
    parameter int MUL_STEP = 2,
    parameter int IMM_W    = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        exe_cmd,
    input  logic              s_in,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic              wb_en,
    input  logic              branch_taken,
    input  logic [DATA_W-1:0] val1,
    input  logic [DATA_W-1:0] val2,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [IMM_W-1:0]  imm_b,
    input  logic [3:0]        dest,
    input  logic              c_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [DATA_W-1:0] branch_addr,
    output logic [3:0]        dest_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic              wb_en_out,
    output logic              branch_taken_out,
    output logic              flags_we,
    output logic              n_out,
    output logic              z_out,
    output logic              c_out,
    output logic              v_out,
    output logic              stall_req
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MUL = 4'b1010;

    if ((DATA_W < 8) || (DATA_W % 2 != 0) || (DATA_W % MUL_STEP != 0)) begin : g_bad_param
        $error("exe_stage_mc: DATA_W must be even, >= 8 and a multiple of MUL_STEP");
    end

`ifdef EXE_MUL_EN
    localparam int NSTEPS = DATA_W / MUL_STEP;
    localparam int CW     = $clog2(NSTEPS + 1);
    typedef enum logic {IDLE, BUSY} state_t;
`else
    typedef enum logic {IDLE} state_t;
`endif

    state_t state;

    logic              mem_r_q, mem_w_q, wb_q, bt_q, s_q;
    logic              accept, is_mul, cmd_def, wb_keep;
    logic              cin, arith, c_res, v_res;
    logic [DATA_W-1:0] op_b, res;
    logic [DATA_W:0]   sum;
    logic signed [IMM_W-1:0] imm_s;
    logic [DATA_W-1:0] imm_ext, branch_next;

`ifdef EXE_MUL_EN
    logic [DATA_W-1:0] acc, mcand, mplier, pp_first, acc_next;
    logic [CW-1:0]     cnt;

    // The first partial product retires on the accept edge, so the whole
    // multiply takes DATA_W/MUL_STEP edges including that one.
    assign pp_first = val1 * DATA_W'(val2[MUL_STEP-1:0]);
    assign acc_next = acc + mcand * DATA_W'(mplier[MUL_STEP-1:0]);
    assign is_mul   = (exe_cmd == CMD_MUL);
    assign wb_keep  = wb_en;
    assign stall_req = (state == BUSY);
`else
    assign is_mul    = 1'b0;
    assign wb_keep   = wb_en & (exe_cmd != CMD_MUL);
    assign stall_req = 1'b0;
`endif

    assign in_ready = (state == IDLE) & !freeze & !flush;
    assign accept   = in_valid & in_ready;

    assign imm_s       = imm_b;
    assign imm_ext     = DATA_W'(imm_s);
    assign branch_next = pc_in + (imm_ext << 2);

    always_comb begin
        op_b    = val2;
        cin     = 1'b0;
        arith   = 1'b0;
        sum     = '0;
        res     = '0;
        cmd_def = 1'b1;
        c_res   = c_in;
        v_res   = 1'b0;
        case (exe_cmd)
            CMD_MOV: res = val2;
            CMD_MVN: res = ~val2;
            CMD_ADD: arith = 1'b1;
            CMD_ADC: begin arith = 1'b1; cin = c_in; end
            CMD_SUB: begin arith = 1'b1; op_b = ~val2; cin = 1'b1; end
            CMD_SBC: begin arith = 1'b1; op_b = ~val2; cin = c_in; end
            CMD_AND: res = val1 & val2;
            CMD_ORR: res = val1 | val2;
            CMD_EOR: res = val1 ^ val2;
`ifdef EXE_MUL_EN
            CMD_MUL: res = pp_first;
`endif
            default: cmd_def = 1'b0;
        endcase
        // Subtraction is a + ~b + carry, so the carry out is already NOT borrow.
        if (arith) begin
            sum   = {1'b0, val1} + {1'b0, op_b} + {{DATA_W{1'b0}}, cin};
            res   = sum[DATA_W-1:0];
            c_res = sum[DATA_W];
            v_res = (val1[DATA_W-1] == op_b[DATA_W-1]) && (res[DATA_W-1] != val1[DATA_W-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            alu_res     <= '0;
            val_rm_out  <= '0;
            branch_addr <= '0;
            dest_out    <= '0;
            mem_r_q     <= 1'b0;
            mem_w_q     <= 1'b0;
            wb_q        <= 1'b0;
            bt_q        <= 1'b0;
            s_q         <= 1'b0;
            n_out       <= 1'b0;
            z_out       <= 1'b0;
            c_out       <= 1'b0;
            v_out       <= 1'b0;
`ifdef EXE_MUL_EN
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
`endif
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            mem_r_q   <= 1'b0;
            mem_w_q   <= 1'b0;
            wb_q      <= 1'b0;
            bt_q      <= 1'b0;
            s_q       <= 1'b0;
`ifdef EXE_MUL_EN
            cnt <= '0;
`endif
        end else if (!freeze) begin
            if (state == IDLE) begin
                if (accept) begin
                    val_rm_out  <= val_rm;
                    branch_addr <= branch_next;
                    dest_out    <= dest;
                    mem_r_q     <= mem_r_en;
                    mem_w_q     <= mem_w_en;
                    wb_q        <= wb_keep;
                    bt_q        <= branch_taken;
                    s_q         <= s_in & cmd_def;
                    alu_res     <= res;
                    n_out       <= res[DATA_W-1];
                    z_out       <= (res == '0);
                    c_out       <= c_res;
                    v_out       <= v_res;
                    out_valid   <= 1'b1;
`ifdef EXE_MUL_EN
                    if (is_mul && (NSTEPS > 1)) begin
                        out_valid <= 1'b0;
                        state     <= BUSY;
                        acc       <= pp_first;
                        mcand     <= val1 << MUL_STEP;
                        mplier    <= val2 >> MUL_STEP;
                        cnt       <= CW'(NSTEPS);
                    end
`endif
                end else begin
                    out_valid <= 1'b0;
                end
            end
`ifdef EXE_MUL_EN
            else begin
                acc    <= acc_next;
                mcand  <= mcand << MUL_STEP;
                mplier <= mplier >> MUL_STEP;
                cnt    <= cnt - CW'(1);
                if (cnt == CW'(2)) begin
                    alu_res   <= acc_next;
                    n_out     <= acc_next[DATA_W-1];
                    z_out     <= (acc_next == '0);
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
            end
`endif
        end
    end

    assign mem_r_en_out     = out_valid & mem_r_q;
    assign mem_w_en_out     = out_valid & mem_w_q;
    assign wb_en_out        = out_valid & wb_q;
    assign branch_taken_out = out_valid & bt_q;
    assign flags_we         = out_valid & s_q;

endmodule

// File: tb/tb_exe_stage_mc.sv
// tb/tb_exe_stage_mc.sv - directed self-checking bench for exe_stage_mc
module tb_exe_stage_mc;

    logic        clk, rst, freeze, flush, in_valid, in_ready;
    logic [3:0]  exe_cmd, dest, dest_out;
    logic        s_in, mem_r_en, mem_w_en, wb_en, branch_taken, c_in;
    logic [31:0] val1, val2, val_rm, pc_in;
    logic [23:0] imm_b;
    logic        out_valid;
    logic [31:0] alu_res, val_rm_out, branch_addr;
    logic        mem_r_en_out, mem_w_en_out, wb_en_out, branch_taken_out;
    logic        flags_we, n_out, z_out, c_out, v_out, stall_req;

    int checks = 0;
    int errors = 0;

    exe_stage_mc #(.DATA_W(32), .MUL_STEP(2), .IMM_W(24)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .exe_cmd(exe_cmd),
        .s_in(s_in), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en),
        .branch_taken(branch_taken), .val1(val1), .val2(val2), .val_rm(val_rm),
        .pc_in(pc_in), .imm_b(imm_b), .dest(dest), .c_in(c_in),
        .out_valid(out_valid), .alu_res(alu_res), .val_rm_out(val_rm_out),
        .branch_addr(branch_addr), .dest_out(dest_out),
        .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .wb_en_out(wb_en_out), .branch_taken_out(branch_taken_out),
        .flags_we(flags_we), .n_out(n_out), .z_out(z_out), .c_out(c_out),
        .v_out(v_out), .stall_req(stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        freeze = 0; flush = 0; in_valid = 0; exe_cmd = 4'b0000;
        s_in = 0; mem_r_en = 0; mem_w_en = 0; wb_en = 0; branch_taken = 0; c_in = 0;
        val1 = '0; val2 = '0; val_rm = '0; pc_in = '0; imm_b = '0; dest = '0;
    endtask

    task automatic drive(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic c);
        in_valid = 1; exe_cmd = cmd; val1 = a; val2 = b; s_in = s; c_in = c;
        wb_en = 1; dest = 4'd5;
    endtask

    task automatic test_reset;
        clear_in();
        rst = 1;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (alu_res !== 32'h0) begin errors++; $display("FAIL reset_alu_res got %h exp 0", alu_res); end
        checks++; if (branch_addr !== 32'h0) begin errors++; $display("FAIL reset_branch_addr got %h exp 0", branch_addr); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall_req got %b exp 0", stall_req); end
        checks++; if ({flags_we, wb_en_out, mem_r_en_out} !== 3'b000) begin errors++; $display("FAIL reset_enables got %b exp 000", {flags_we, wb_en_out, mem_r_en_out}); end
        @(negedge clk);
        rst = 0;
        tick();
    endtask

    task automatic test_add;
        clear_in();
        drive(4'b0010, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready got %b exp 1", in_ready); end
        tick();
        clear_in();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid got %b exp 1", out_valid); end
        checks++; if (alu_res !== 32'h0) begin errors++; $display("FAIL add_res got %h exp 0", alu_res); end
        checks++; if ({n_out, z_out, c_out, v_out} !== 4'b0110) begin errors++; $display("FAIL add_nzcv got %b exp 0110", {n_out, z_out, c_out, v_out}); end
        checks++; if (flags_we !== 1'b1) begin errors++; $display("FAIL add_flags_we got %b exp 1", flags_we); end
        checks++; if ({wb_en_out, dest_out} !== {1'b1, 4'd5}) begin errors++; $display("FAIL add_wb_dest got %b/%0d exp 1/5", wb_en_out, dest_out); end
        tick();
        checks++; if ({out_valid, wb_en_out, flags_we} !== 3'b000) begin errors++; $display("FAIL bubble_after_add got %b exp 000", {out_valid, wb_en_out, flags_we}); end
    endtask

    task automatic test_sub;
        clear_in();
        drive(4'b0100, 32'h8000_0000, 32'h1, 1'b1, 1'b0);
        tick();
        clear_in();
        checks++; if (alu_res !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sub_res got %h exp 7fffffff", alu_res); end
        checks++; if ({n_out, c_out, v_out} !== 3'b011) begin errors++; $display("FAIL sub_ncv got %b exp 011", {n_out, c_out, v_out}); end
    endtask

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] a, b;
        logic        cin;
        logic [31:0] res;
        logic        c, v, fwe;
    } vec_t;

    task automatic test_alu_table;
        vec_t tbl[10];
        tbl[0] = '{4'b0001, 32'h5, 32'h1234, 1'b1, 32'h1234, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{4'b1001, 32'h5, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{4'b0011, 32'h7FFF_FFFF, 32'h0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{4'b0101, 32'h5, 32'h3, 1'b0, 32'h1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{4'b0101, 32'h0, 32'h1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{4'b0110, 32'hF0F0, 32'hFF00, 1'b0, 32'hF000, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{4'b0111, 32'hF0F0, 32'h0F0F, 1'b1, 32'hFFFF, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{4'b1000, 32'hFF00, 32'h0FF0, 1'b0, 32'hF0F0, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{4'b0000, 32'h12, 32'h34, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{4'b1111, 32'h12, 32'h34, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            clear_in();
            drive(tbl[i].cmd, tbl[i].a, tbl[i].b, 1'b1, tbl[i].cin);
            tick();
            checks++; if (alu_res !== tbl[i].res) begin errors++; $display("FAIL alu_res[%0d] got %h exp %h", i, alu_res, tbl[i].res); end
            checks++; if ({c_out, v_out} !== {tbl[i].c, tbl[i].v}) begin errors++; $display("FAIL alu_cv[%0d] got %b exp %b", i, {c_out, v_out}, {tbl[i].c, tbl[i].v}); end
            checks++; if ({out_valid, flags_we} !== {1'b1, tbl[i].fwe}) begin errors++; $display("FAIL alu_valid_fwe[%0d] got %b exp %b", i, {out_valid, flags_we}, {1'b1, tbl[i].fwe}); end
        end
        clear_in();
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_res [3];
        exp_res[0] = 32'd3; exp_res[1] = 32'd30; exp_res[2] = 32'd300;
        clear_in();
        for (int i = 0; i < 3; i++) begin
            drive(4'b0010, (i == 0) ? 32'd1 : (i == 1) ? 32'd10 : 32'd100,
                  (i == 0) ? 32'd2 : (i == 1) ? 32'd20 : 32'd200, 1'b0, 1'b0);
            tick();
            checks++; if ({out_valid, alu_res} !== {1'b1, exp_res[i]}) begin errors++; $display("FAIL b2b[%0d] got %b/%0d exp 1/%0d", i, out_valid, alu_res, exp_res[i]); end
        end
        clear_in();
        tick();
    endtask

    task automatic test_branch;
        clear_in();
        drive(4'b0010, 32'h0, 32'h0, 1'b0, 1'b0);
        wb_en = 0; pc_in = 32'h100; imm_b = 24'hFFFFFE; branch_taken = 1;
        tick();
        clear_in();
        checks++; if (branch_addr !== 32'hF8) begin errors++; $display("FAIL branch_neg got %h exp f8", branch_addr); end
        checks++; if (branch_taken_out !== 1'b1) begin errors++; $display("FAIL branch_taken_on got %b exp 1", branch_taken_out); end
        tick();
        checks++; if (branch_taken_out !== 1'b0) begin errors++; $display("FAIL branch_taken_off got %b exp 0", branch_taken_out); end
        drive(4'b0010, 32'h0, 32'h0, 1'b0, 1'b0);
        pc_in = 32'h100; imm_b = 24'h000004;
        tick();
        clear_in();
        checks++; if (branch_addr !== 32'h110) begin errors++; $display("FAIL branch_pos got %h exp 110", branch_addr); end
    endtask

    task automatic test_freeze;
        clear_in();
        drive(4'b0010, 32'd7, 32'd8, 1'b0, 1'b0);
        tick();
        drive(4'b0100, 32'd1, 32'd1, 1'b0, 1'b0);
        freeze = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL freeze_in_ready got %b exp 0", in_ready); end
        tick(); tick();
        checks++; if ({out_valid, alu_res} !== {1'b1, 32'd15}) begin errors++; $display("FAIL freeze_hold got %b/%0d exp 1/15", out_valid, alu_res); end
        clear_in();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL freeze_release got %b exp 0", out_valid); end
    endtask

    task automatic test_flush;
        clear_in();
        drive(4'b0010, 32'd1, 32'd1, 1'b0, 1'b0);
        flush = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
        tick();
        checks++; if ({out_valid, wb_en_out} !== 2'b00) begin errors++; $display("FAIL flush_bubble got %b exp 00", {out_valid, wb_en_out}); end
        clear_in();
        drive(4'b0010, 32'd1, 32'd1, 1'b0, 1'b0);
        tick();
        clear_in();
        flush = 1; freeze = 1;
        tick();
        clear_in();
        checks++; if ({out_valid, wb_en_out} !== 2'b00) begin errors++; $display("FAIL flush_over_freeze got %b exp 00", {out_valid, wb_en_out}); end
    endtask

`ifdef EXE_MUL_EN
    task automatic test_mul;
        int n, stalls, seen;
        clear_in();
        drive(4'b1010, 32'h0001_0003, 32'h0000_0005, 1'b1, 1'b0);
        tick();
        clear_in();
        checks++; if ({in_ready, out_valid} !== 2'b00) begin errors++; $display("FAIL mul_busy_ready got %b exp 00", {in_ready, out_valid}); end
        n = 1; stalls = 0;
        while (!out_valid && n < 40) begin
            if (stall_req) stalls++;
            tick();
            n++;
        end
        checks++; if (n != 16) begin errors++; $display("FAIL mul_latency got %0d exp 16", n); end
        checks++; if (stalls != 15) begin errors++; $display("FAIL mul_stall_cycles got %0d exp 15", stalls); end
        checks++; if (alu_res !== 32'h0005_000F) begin errors++; $display("FAIL mul_res got %h exp 0005000f", alu_res); end
        checks++; if ({wb_en_out, flags_we, stall_req} !== 3'b110) begin errors++; $display("FAIL mul_ctrl got %b exp 110", {wb_en_out, flags_we, stall_req}); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_pulse got %b exp 0", out_valid); end

        drive(4'b1010, 32'h1234_5678, 32'h3, 1'b0, 1'b0);
        tick();
        clear_in();
        tick(); tick();
        freeze = 1;
        tick(); tick(); tick();
        freeze = 0;
        n = 6;
        while (!out_valid && n < 40) begin tick(); n++; end
        checks++; if (n != 19) begin errors++; $display("FAIL mul_freeze_latency got %0d exp 19", n); end
        checks++; if (alu_res !== 32'h369D_0368) begin errors++; $display("FAIL mul_freeze_res got %h exp 369d0368", alu_res); end

        drive(4'b1010, 32'd9, 32'd9, 1'b0, 1'b0);
        tick();
        clear_in();
        tick(); tick(); tick();
        flush = 1;
        tick();
        flush = 0;
        checks++; if ({out_valid, stall_req, in_ready} !== 3'b001) begin errors++; $display("FAIL mul_flush got %b exp 001", {out_valid, stall_req, in_ready}); end
        seen = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (out_valid) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL mul_flush_no_valid got %0d exp 0", seen); end

        drive(4'b1010, 32'd7, 32'd6, 1'b0, 1'b0);
        tick();
        clear_in();
        tick(); tick(); tick(); tick();
        #2 rst = 1;
        #1;
        checks++; if ({out_valid, in_ready, stall_req} !== 3'b010) begin errors++; $display("FAIL mul_reset got %b exp 010", {out_valid, in_ready, stall_req}); end
        @(negedge clk);
        rst = 0;
        tick();
        drive(4'b0010, 32'd2, 32'd3, 1'b0, 1'b0);
        tick();
        clear_in();
        checks++; if ({out_valid, alu_res} !== {1'b1, 32'd5}) begin errors++; $display("FAIL add_after_reset got %b/%0d exp 1/5", out_valid, alu_res); end
    endtask
`else
    task automatic test_mul;
        clear_in();
        drive(4'b1010, 32'd3, 32'd4, 1'b1, 1'b0);
        tick();
        clear_in();
        checks++; if ({out_valid, alu_res} !== {1'b1, 32'h0}) begin errors++; $display("FAIL mul_undef_res got %b/%h exp 1/0", out_valid, alu_res); end
        checks++; if ({flags_we, wb_en_out, stall_req, in_ready} !== 4'b0001) begin errors++; $display("FAIL mul_undef_ctrl got %b exp 0001", {flags_we, wb_en_out, stall_req, in_ready}); end
    endtask
`endif

    initial begin
        rst = 1;
        clear_in();
        test_reset();
        test_add();
        test_sub();
        test_alu_table();
        test_back_to_back();
        test_branch();
        test_freeze();
        test_flush();
        test_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
